// File: rtl/fmul32_rsh_round.sv
// F32 multiplier subnormal/underflow path: right-shift, round and pack the product.
// Latency: 2 cycles (input register, then result register); 1 op/cycle when out_ready_i=1.
// Backpressure: a stalled result blocks stage 1, which then drops in_ready_o; flush_i empties both stages.

// Builds the L/G/S bit masks for a right shift of (23+rsh) and the uf_check variants.
// The uf_check masks sit one bit lower: they round as if the exponent were unbounded.
module fmul32_rsh_lgs_mask (
  input  logic [4:0]  rsh_num_i,
  output logic [47:0] l_mask_o,
  output logic [47:0] g_mask_o,
  output logic [47:0] s_mask_o,
  output logic [47:0] lu_mask_o,
  output logic [47:0] gu_mask_o,
  output logic [47:0] su_mask_o
);
  logic [5:0] l_pos;
  logic [5:0] g_pos;
  logic [5:0] gu_pos;

  assign l_pos  = 6'd23 + {1'b0, rsh_num_i};
  assign g_pos  = l_pos - 6'd1;
  assign gu_pos = l_pos - 6'd2;

  // A shift of 48 or more yields zero, so L and G vanish for large shifts;
  // the sticky mask then wraps to all ones and covers the whole significand.
  assign l_mask_o  = 48'd1 << l_pos;
  assign g_mask_o  = 48'd1 << g_pos;
  assign s_mask_o  = (48'd1 << g_pos) - 48'd1;
  assign lu_mask_o = 48'd1 << g_pos;
  assign gu_mask_o = 48'd1 << gu_pos;
  assign su_mask_o = (48'd1 << gu_pos) - 48'd1;
endmodule

module fmul32_rsh_round (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic        sign_i,
  input  logic [47:0] sig_mul_i,
  input  logic [4:0]  rsh_num_i,
  input  logic [2:0]  rm_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] res_o,
  output logic        nx_o,
  output logic        uf_o
);
  // Rounding-mode increment decision; encodings 5..7 fall back to RNE.
  function automatic logic rnd_inc(input logic [2:0] rm, input logic sgn,
                                   input logic l, input logic g, input logic s);
    case (rm)
      3'd1:    rnd_inc = 1'b0;
      3'd2:    rnd_inc = sgn & (g | s);
      3'd3:    rnd_inc = ~sgn & (g | s);
      3'd4:    rnd_inc = g;
      default: rnd_inc = g & (l | s);
    endcase
  endfunction

  logic        s1_valid_q, s2_valid_q;
  logic        s1_adv, in_fire, s1_fire;

  logic [47:0] l_mask, g_mask, s_mask, lu_mask, gu_mask, su_mask;
  logic [5:0]  ret_sh;

  logic        l_d, g_d, s_d, lu_d, gu_d, su_d;
  logic        l_q, g_q, s_q, lu_q, gu_q, su_q;
  logic [23:0] ret_d, ret_q;
  logic        hi_ones_d, b47_d, rsh1_d;
  logic        hi_ones_q, b47_q, rsh1_q;
  logic        sign_q;
  logic [2:0]  rm_q;

  logic        inc, inc_u, tiny;
  logic [31:0] res_d, res_q;
  logic        nx_d, nx_q, uf_d, uf_q;

  fmul32_rsh_lgs_mask u_mask (
    .rsh_num_i (rsh_num_i),
    .l_mask_o  (l_mask),
    .g_mask_o  (g_mask),
    .s_mask_o  (s_mask),
    .lu_mask_o (lu_mask),
    .gu_mask_o (gu_mask),
    .su_mask_o (su_mask)
  );

  // Stage 1 may move forward whenever stage 2 is empty or being drained.
  assign s1_adv     = ~s2_valid_q | out_ready_i;
  assign in_ready_o = rst_n & ~flush_i & (~s1_valid_q | s1_adv);
  assign in_fire    = in_valid_i & in_ready_o;
  assign s1_fire    = s1_valid_q & s1_adv & ~flush_i;

  // Extract rounding bits and the retained significand from the incoming product.
  always_comb begin
    ret_sh    = 6'd23 + {1'b0, rsh_num_i};
    ret_d     = 24'(sig_mul_i >> ret_sh);
    l_d       = |(sig_mul_i & l_mask);
    g_d       = |(sig_mul_i & g_mask);
    s_d       = |(sig_mul_i & s_mask);
    lu_d      = |(sig_mul_i & lu_mask);
    gu_d      = |(sig_mul_i & gu_mask);
    su_d      = |(sig_mul_i & su_mask);
    hi_ones_d = &sig_mul_i[46:23];
    b47_d     = sig_mul_i[47];
    rsh1_d    = (rsh_num_i == 5'd1);
  end

  // Stage-1 occupancy: fill on accept, empty when handed on, flush/reset win.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
    end else if (flush_i) begin
      s1_valid_q <= 1'b0;
    end else if (in_fire) begin
      s1_valid_q <= 1'b1;
    end else if (s1_adv) begin
      s1_valid_q <= 1'b0;
    end
  end

  // Stage-1 payload; stale contents are harmless while s1_valid_q is low.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      l_q       <= l_d;
      g_q       <= g_d;
      s_q       <= s_d;
      lu_q      <= lu_d;
      gu_q      <= gu_d;
      su_q      <= su_d;
      ret_q     <= ret_d;
      hi_ones_q <= hi_ones_d;
      b47_q     <= b47_d;
      rsh1_q    <= rsh1_d;
      sign_q    <= sign_i;
      rm_q      <= rm_i;
    end
  end

  // Round, pack and flag. A carry out of the 24-bit field bumps the exponent.
  // Tininess is judged after rounding: only a rsh=1 value that reaches 2^-126
  // at full precision escapes underflow.
  always_comb begin
    inc   = rnd_inc(rm_q, sign_q, l_q, g_q, s_q);
    inc_u = rnd_inc(rm_q, sign_q, lu_q, gu_q, su_q);
    res_d = {sign_q, 7'b0, ret_q} + {31'b0, inc};
    nx_d  = g_q | s_q;
    tiny  = ~(rsh1_q & (b47_q | (hi_ones_q & inc_u)));
    uf_d  = tiny & nx_d;
  end

  // Stage-2 occupancy: fill from stage 1, empty when consumed, flush/reset win.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
    end else if (flush_i) begin
      s2_valid_q <= 1'b0;
    end else if (s1_valid_q & s1_adv) begin
      s2_valid_q <= 1'b1;
    end else if (out_ready_i) begin
      s2_valid_q <= 1'b0;
    end
  end

  // Result register: cleared by reset, held during a stall, kept stale on flush.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q <= 32'b0;
      nx_q  <= 1'b0;
      uf_q  <= 1'b0;
    end else if (s1_fire) begin
      res_q <= res_d;
      nx_q  <= nx_d;
      uf_q  <= uf_d;
    end
  end

  assign out_valid_o = s2_valid_q;
  assign res_o       = res_q;
  assign nx_o        = nx_q;
  assign uf_o        = uf_q;
endmodule

// File: tb/tb_fmul32_rsh_round.sv
module tb_fmul32_rsh_round;
  logic        clk = 1'b0;
  logic        rst_n, flush_i, in_valid_i, in_ready_o, sign_i;
  logic [47:0] sig_mul_i;
  logic [4:0]  rsh_num_i;
  logic [2:0]  rm_i;
  logic        out_valid_o, out_ready_i, nx_o, uf_o;
  logic [31:0] res_o;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [33:0] exp_q[$];
  bit          rand_bp = 1'b0;

  always #5 clk = ~clk;

  fmul32_rsh_round dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .sign_i      (sign_i),
    .sig_mul_i   (sig_mul_i),
    .rsh_num_i   (rsh_num_i),
    .rm_i        (rm_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .res_o       (res_o),
    .nx_o        (nx_o),
    .uf_o        (uf_o)
  );

  // Reference rounding: compare the discarded remainder against one half ulp.
  function automatic bit round_up(input logic [2:0] rm, input logic sgn, input bit odd,
                                  input longint unsigned rem, input longint unsigned half);
    case (rm)
      3'd1:    return 1'b0;
      3'd2:    return sgn && (rem != 0);
      3'd3:    return !sgn && (rem != 0);
      3'd4:    return rem >= half;
      default: return (rem > half) || ((rem == half) && odd);
    endcase
  endfunction

  // Reference result {uf, nx, res} from the arithmetic value of the product.
  function automatic logic [33:0] model(input logic sgn, input logic [47:0] sig,
                                        input logic [4:0] rsh, input logic [2:0] rm);
    longint unsigned v, keep, rem, half, mag, ku, remu;
    int sh;
    bit tiny, nx;
    logic [31:0] r;
    v    = 64'(sig);
    sh   = 23 + int'(rsh);
    keep = v >> sh;
    rem  = v & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    mag  = keep + 64'(round_up(rm, sgn, (keep & 64'd1) != 0, rem, half));
    nx   = (rem != 0);
    if (rsh != 5'd1) tiny = 1'b1;
    else if (sig[47]) tiny = 1'b0;
    else begin
      ku   = v >> 23;
      remu = v & ((64'd1 << 23) - 64'd1);
      ku   = ku + 64'(round_up(rm, sgn, (ku & 64'd1) != 0, remu, 64'd1 << 22));
      tiny = (ku < (64'd1 << 24));
    end
    r = {sgn, 31'(mag)};
    return {tiny && nx, nx, r};
  endfunction

  task automatic chk(input string tag, input logic [33:0] got, input logic [33:0] expv);
    n_cmp++;
    assert (got === expv) else begin
      n_bad++;
      $error("FAIL %s got=%h expected=%h", tag, got, expv);
    end
  endtask

  // Output scoreboard: every consumed result must match the oldest expectation.
  always @(negedge clk) begin
    if (out_valid_o && out_ready_i) begin
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_bad++;
        $error("FAIL out_extra got=%h expected=none", res_o);
      end
      if (exp_q.size() != 0) chk("out_data", {uf_o, nx_o, res_o}, exp_q.pop_front());
    end
  end

  // Present one op and hold it until accepted; expv is what must come out.
  task automatic send(input logic sgn, input logic [47:0] sig, input logic [4:0] rsh,
                      input logic [2:0] rm, input logic [33:0] expv);
    int t = 0;
    in_valid_i = 1'b1; sign_i = sgn; sig_mul_i = sig; rsh_num_i = rsh; rm_i = rm;
    @(negedge clk);
    while (!in_ready_o && t < 50) begin
      @(posedge clk); #1;
      if (rand_bp) out_ready_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      t++;
    end
    n_cmp++;
    assert (in_ready_o) else begin
      n_bad++;
      $error("FAIL accept_timeout in_ready=%b expected=1", in_ready_o);
    end
    if (in_ready_o) exp_q.push_back(expv);
    @(posedge clk); #1;
    in_valid_i = 1'b0;
  endtask

  task automatic send_m(input logic sgn, input logic [47:0] sig, input logic [4:0] rsh,
                        input logic [2:0] rm);
    send(sgn, sig, rsh, rm, model(sgn, sig, rsh, rm));
  endtask

  task automatic drain();
    int t = 0;
    out_ready_i = 1'b1;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain_left", 34'(exp_q.size()), 34'd0);
  endtask

  initial begin
    int cyc;
    logic [31:0] snap;
    logic [47:0] sig;
    logic [4:0]  rsh;

    // Reset state, with an input offered that must not be taken.
    rst_n = 1'b0; flush_i = 1'b0; in_valid_i = 1'b1; out_ready_i = 1'b1;
    sign_i = 1'b0; sig_mul_i = 48'h800000_000000; rsh_num_i = 5'd1; rm_i = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 34'(in_ready_o), 34'd0);
    chk("rst_out_valid", 34'(out_valid_o), 34'd0);
    chk("rst_res", 34'(res_o), 34'd0);
    chk("rst_nx", 34'(nx_o), 34'd0);
    chk("rst_uf", 34'(uf_o), 34'd0);
    in_valid_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Latency: result visible two cycles after the accept cycle.
    in_valid_i = 1'b1; sign_i = 1'b0; sig_mul_i = 48'h800000_000000; rsh_num_i = 5'd1; rm_i = 3'd0;
    exp_q.push_back({1'b0, 1'b0, 32'h0080_0000});
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    cyc = 1;
    while (!out_valid_o && cyc < 10) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", 34'(cyc), 34'd2);
    chk("lat_res", {uf_o, nx_o, res_o}, {1'b0, 1'b0, 32'h0080_0000});
    drain();

    // Directed rounding, carry and tininess cases.
    send(1'b0, 48'h000001_800000, 5'd1,  3'd0, {1'b1, 1'b1, 32'h0000_0002});
    send(1'b0, 48'h000001_800000, 5'd1,  3'd1, {1'b1, 1'b1, 32'h0000_0001});
    send(1'b0, 48'h000001_800000, 5'd1,  3'd7, {1'b1, 1'b1, 32'h0000_0002});
    send(1'b0, 48'h800000_000000, 5'd25, 3'd0, {1'b1, 1'b1, 32'h0000_0000});
    send(1'b0, 48'h800000_000000, 5'd25, 3'd4, {1'b1, 1'b1, 32'h0000_0001});
    send(1'b1, 48'h800000_000000, 5'd25, 3'd2, {1'b1, 1'b1, 32'h8000_0001});
    send(1'b1, 48'h800000_000000, 5'd25, 3'd3, {1'b1, 1'b1, 32'h8000_0000});
    send(1'b0, 48'h7FFFFF_C00000, 5'd1,  3'd0, {1'b0, 1'b1, 32'h0080_0000});
    send_m(1'b0, 48'h7FFFFF_400000, 5'd1, 3'd0);
    send(1'b0, 48'hFFFFFF_800000, 5'd1,  3'd0, {1'b0, 1'b1, 32'h0100_0000});
    send(1'b0, 48'h000000_000001, 5'd30, 3'd3, {1'b1, 1'b1, 32'h0000_0001});
    send(1'b0, 48'hFFFFFF_FFFFFF, 5'd31, 3'd0, {1'b1, 1'b1, 32'h0000_0000});
    drain();

    // Backpressure: two accepts fill the pipe, then input stalls and output holds.
    out_ready_i = 1'b0;
    send_m(1'b0, 48'h123456_789ABC, 5'd1, 3'd0);
    send_m(1'b1, 48'hFEDCBA_987654, 5'd3, 3'd2);
    in_valid_i = 1'b1; sign_i = 1'b0; sig_mul_i = 48'h400000_000001; rsh_num_i = 5'd2; rm_i = 3'd3;
    @(negedge clk);
    chk("bp_in_ready", 34'(in_ready_o), 34'd0);
    chk("bp_out_valid", 34'(out_valid_o), 34'd1);
    snap = res_o;
    repeat (2) begin
      @(negedge clk);
      chk("bp_hold", 34'(res_o), 34'(snap));
    end
    @(posedge clk); #1;
    out_ready_i = 1'b1;
    send_m(1'b0, 48'h400000_000001, 5'd2, 3'd3);
    send_m(1'b1, 48'h0F0F0F_0F0F0F, 5'd1, 3'd4);
    drain();

    // Flush with both stages full and an input offered.
    out_ready_i = 1'b0;
    send_m(1'b0, 48'h800000_000000, 5'd1, 3'd0);
    send_m(1'b0, 48'hFFFFFF_800000, 5'd1, 3'd0);
    flush_i = 1'b1; in_valid_i = 1'b1; sig_mul_i = 48'h555555_555555; rsh_num_i = 5'd4;
    @(negedge clk);
    chk("flush_in_ready", 34'(in_ready_o), 34'd0);
    @(posedge clk); #1;
    flush_i = 1'b0; in_valid_i = 1'b0;
    exp_q.delete();
    chk("flush_out_valid", 34'(out_valid_o), 34'd0);
    out_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("flush_no_accept", 34'(out_valid_o), 34'd0);
    send_m(1'b1, 48'h000001_800000, 5'd1, 3'd0);
    drain();

    // Reset mid-stream discards everything and clears the outputs.
    out_ready_i = 1'b0;
    send_m(1'b0, 48'h800000_000000, 5'd1, 3'd0);
    send_m(1'b1, 48'hFFFFFF_800000, 5'd1, 3'd0);
    rst_n = 1'b0; in_valid_i = 1'b1;
    @(negedge clk);
    chk("mrst_in_ready", 34'(in_ready_o), 34'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; in_valid_i = 1'b0;
    exp_q.delete();
    chk("mrst_outputs", {uf_o, nx_o, res_o}, 34'd0);
    chk("mrst_out_valid", 34'(out_valid_o), 34'd0);
    out_ready_i = 1'b1;
    send_m(1'b0, 48'h7FFFFF_C00000, 5'd1, 3'd0);
    drain();

    // Random ops with random output backpressure.
    rand_bp = 1'b1;
    for (int i = 0; i < 200; i++) begin
      out_ready_i = ($urandom_range(0, 3) != 0);
      rsh = ($urandom_range(0, 1) != 0) ? 5'd1 : 5'($urandom_range(1, 31));
      sig = {16'($urandom), 32'($urandom)};
      if ($urandom_range(0, 3) == 0) sig[47:23] = {1'b0, 24'hFFFFFF};
      send_m(1'($urandom_range(0, 1)), sig, rsh, 3'($urandom_range(0, 7)));
    end
    rand_bp = 1'b0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
